mag_rr_sched: RTL and testbench

- Round-robin scheduler that shares one multi-cycle magnitude engine (r = sqrt(x^2 + y^2), 8-bit operands) between two requesters.
- Accepts jobs over valid/ready and launches the engine with a one-cycle start pulse.
- Waits for the engine's done flag under a watchdog, then returns the result tagged with the requester ID over a valid/ready response channel.
- Sits between the I/O wrappers and the shared magnitude datapath.

---
 rtl/mag_rr_sched_if.sv | 47 ++++
 rtl/mag_rr_sched.sv | 118 +++++++++++
 tb/tb_mag_rr_sched.sv | 374 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mag_rr_sched_if.sv
// Bundle of the job, engine and response channels around mag_rr_sched.
//
// Handshake rule for the job (reqN_*) and response (rsp_*) channels:
// a transfer happens on a rising clk edge where valid and ready are both 1.
// Once the source raises valid it holds valid and the payload stable until
// that transfer. Ready may depend combinationally on valid. The engine
// channel is not a handshake: eng_start, eng_abort and eng_done are
// single-cycle pulses.
interface mag_rr_sched_if #(
  parameter int W = 8
);
  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_x;
  logic [W-1:0] req0_y;
  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_x;
  logic [W-1:0] req1_y;
  logic         eng_start;
  logic [W-1:0] eng_x;
  logic [W-1:0] eng_y;
  logic         eng_abort;
  logic         eng_done;
  logic [W-1:0] eng_r;
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic [W-1:0] rsp_r;
  logic         rsp_err;

  // Scheduler side
  modport slave (
    input  req0_valid, req0_x, req0_y, req1_valid, req1_x, req1_y,
    input  eng_done, eng_r, rsp_ready,
    output req0_ready, req1_ready, eng_start, eng_x, eng_y, eng_abort,
    output rsp_valid, rsp_id, rsp_r, rsp_err
  );

  // Requester / engine / consumer side
  modport master (
    output req0_valid, req0_x, req0_y, req1_valid, req1_x, req1_y,
    output eng_done, eng_r, rsp_ready,
    input  req0_ready, req1_ready, eng_start, eng_x, eng_y, eng_abort,
    input  rsp_valid, rsp_id, rsp_r, rsp_err
  );
endinterface

// File: rtl/mag_rr_sched.sv
// Round-robin scheduler sharing one multi-cycle magnitude engine between
// two requesters. A job is accepted in IDLE, launched with a one-cycle
// start pulse in ISSUE, guarded by a watchdog in WAIT and returned tagged
// with its requester ID in RESP. ena low freezes every register.
module mag_rr_sched #(
  parameter int TIMEOUT = 32,
  parameter int W       = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  mag_rr_sched_if.slave bus,
  output logic         busy,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic         r_last_grant;
  logic [7:0]   r_wdog;
  logic [W-1:0] r_eng_x;
  logic [W-1:0] r_eng_y;
  logic         r_id;
  logic [W-1:0] r_rsp_r;
  logic         r_rsp_err;
  logic         w_grant_vld;
  logic         w_grant_id;
  logic         w_wdog_exp;

  // Grant: a lone requester wins; on contention the one not served last wins
  always_comb begin
    w_grant_vld = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid & bus.req1_valid) w_grant_id = ~r_last_grant;
    else                                 w_grant_id = bus.req1_valid;
  end

  assign w_wdog_exp = (r_wdog == 8'(TIMEOUT - 1));

  // State register; ena low holds the state so pending pulses are deferred
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   r_state <= S_IDLE;
    else if (ena) r_state <= w_next;
  end

  // Next-state logic; only takes effect in enabled cycles
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_grant_vld) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (bus.eng_done || w_wdog_exp) w_next = S_RESP;
      S_RESP:  if (bus.rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM outputs; pulses and ready are masked while ena is low
  always_comb begin
    bus.req0_ready = ena & (r_state == S_IDLE) & w_grant_vld & ~w_grant_id;
    bus.req1_ready = ena & (r_state == S_IDLE) & w_grant_vld &  w_grant_id;
    bus.eng_start  = ena & (r_state == S_ISSUE);
    // done wins over a watchdog expiry in the same cycle
    bus.eng_abort  = ena & (r_state == S_WAIT) & ~bus.eng_done & w_wdog_exp;
    bus.rsp_valid  = (r_state == S_RESP);
    busy           = (r_state != S_IDLE);
    dbg_state      = r_state;
  end

  // Job datapath: operand capture, watchdog and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_wdog       <= 8'd0;
      r_eng_x      <= '0;
      r_eng_y      <= '0;
      r_id         <= 1'b0;
      r_rsp_r      <= '0;
      r_rsp_err    <= 1'b0;
    end else if (ena) begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_vld) begin
            r_eng_x      <= w_grant_id ? bus.req1_x : bus.req0_x;
            r_eng_y      <= w_grant_id ? bus.req1_y : bus.req0_y;
            r_id         <= w_grant_id;
            r_last_grant <= w_grant_id;
          end
        end
        S_ISSUE: r_wdog <= 8'd0;
        S_WAIT: begin
          r_wdog <= r_wdog + 8'd1;
          if (bus.eng_done) begin
            r_rsp_r   <= bus.eng_r;
            r_rsp_err <= 1'b0;
          end else if (w_wdog_exp) begin
            r_rsp_r   <= '0;
            r_rsp_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.eng_x   = r_eng_x;
  assign bus.eng_y   = r_eng_y;
  assign bus.rsp_id  = r_id;
  assign bus.rsp_r   = r_rsp_r;
  assign bus.rsp_err = r_rsp_err;

endmodule

// File: tb/tb_mag_rr_sched.sv
// Bench for mag_rr_sched: engine model with programmable latency, a
// scoreboard of expected {id, r, err} responses, a table of grant/result
// vectors and hand-written multi-cycle sequences.
// Timing per cycle: inputs driven at posedge+1, engine model updates at +2,
// checks at +3, scoreboard monitor at +4.
module tb_mag_rr_sched;
  localparam int W = 8;
  localparam int TIMEOUT = 32;

  logic clk;
  logic rst_n;
  logic ena;
  logic busy;
  logic [1:0] dbg_state;

  mag_rr_sched_if #(.W(W)) bus ();

  mag_rr_sched #(.TIMEOUT(TIMEOUT), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus),
    .busy(busy), .dbg_state(dbg_state)
  );

  typedef struct {
    logic       v0;
    logic [7:0] x0;
    logic [7:0] y0;
    logic       v1;
    logic [7:0] x1;
    logic [7:0] y1;
    int         exp_id;
    int         exp_r;
  } vec_t;

  logic [W+1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc_n = 0;
  int eng_lat = 5;    // 0 = engine never finishes
  logic exp_err = 1'b0;

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int mag(input int x, input int y);
    int s;
    int r;
    s = x * x + y * y;
    r = 0;
    while ((r + 1) * (r + 1) <= s) r++;
    return (r > 255) ? 255 : r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic settle();
    #2;
  endtask

  // engine model: result = saturated floor(sqrt(x^2+y^2)) eng_lat cycles after start
  initial begin : engine
    int e_cnt;
    int e_x;
    int e_y;
    e_cnt = 0; e_x = 0; e_y = 0;
    bus.eng_done = 1'b0;
    bus.eng_r = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        e_cnt = 0;
        bus.eng_done = 1'b0;
      end else begin
        bus.eng_done = 1'b0;
        if (e_cnt > 0) begin
          e_cnt--;
          if (e_cnt == 0) begin
            bus.eng_done = 1'b1;
            bus.eng_r = 8'(mag(e_x, e_y));
          end
        end
        if (bus.eng_start && eng_lat > 0) begin
          e_cnt = eng_lat;
          e_x = int'(bus.eng_x);
          e_y = int'(bus.eng_y);
        end
      end
    end
  end

  // scoreboard: push on job handshake, pop on response handshake
  initial begin : monitor
    logic [W+1:0] e;
    logic [W+1:0] a;
    forever begin
      @(posedge clk);
      #4;
      if (rst_n && ena) begin
        if (bus.req0_valid && bus.req0_ready)
          exp_q.push_back({1'b0, exp_err ? 8'd0 : 8'(mag(int'(bus.req0_x), int'(bus.req0_y))), exp_err});
        if (bus.req1_valid && bus.req1_ready)
          exp_q.push_back({1'b1, exp_err ? 8'd0 : 8'(mag(int'(bus.req1_x), int'(bus.req1_y))), exp_err});
        if (bus.rsp_valid && bus.rsp_ready) begin
          a = {bus.rsp_id, bus.rsp_r, bus.rsp_err};
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_unexpected: got 0x%0h, expected no response", a);
          end else begin
            e = exp_q.pop_front();
            chk("scoreboard", int'(a), int'(e));
          end
        end
      end
    end
  end

  task automatic wait_rsp(input string name);
    int k;
    k = 0;
    while (!bus.rsp_valid && k < 100) begin
      step(); settle(); k++;
    end
    chk(name, int'(bus.rsp_valid), 1);
  endtask

  task automatic wait_abort(input int t0, input int exp_delay);
    int k;
    k = 0;
    while (!bus.eng_abort && k < 100) begin
      step(); settle(); k++;
    end
    chk("abort_delay", cyc_n - t0, exp_delay);
  endtask

  // one job through the table path, rsp_ready held high
  task automatic apply(input vec_t v);
    int got;
    step();
    bus.rsp_ready = 1'b1;
    bus.req0_valid = v.v0; bus.req0_x = v.x0; bus.req0_y = v.y0;
    bus.req1_valid = v.v1; bus.req1_x = v.x1; bus.req1_y = v.y1;
    settle();
    got = bus.req1_ready ? 1 : (bus.req0_ready ? 0 : 2);
    chk("grant_id", got, v.exp_id);
    chk("both_ready", int'(bus.req0_ready & bus.req1_ready), 0);
    step();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    settle();
    wait_rsp("tbl_rsp_seen");
    chk("tbl_rsp_id", int'(bus.rsp_id), v.exp_id);
    chk("tbl_rsp_r", int'(bus.rsp_r), v.exp_r);
    chk("tbl_rsp_err", int'(bus.rsp_err), 0);
    step(); settle();
    chk("tbl_idle", int'(busy), 0);
  endtask

  // global time limit
  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish before limit");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "time limit");
  end

  initial begin : main
    vec_t tbl[8];
    vec_t v;
    int t0;
    int n;
    int k;
    int seen;
    int ids[4];
    int rs[4];

    tbl[0] = '{1'b1, 8'd3,   8'd4,   1'b0, 8'd0, 8'd0,   0, 5};
    tbl[1] = '{1'b1, 8'd6,   8'd8,   1'b1, 8'd5, 8'd12,  1, 13};
    tbl[2] = '{1'b1, 8'd6,   8'd8,   1'b1, 8'd5, 8'd12,  0, 10};
    tbl[3] = '{1'b0, 8'd0,   8'd0,   1'b1, 8'd7, 8'd24,  1, 25};
    tbl[4] = '{1'b0, 8'd0,   8'd0,   1'b1, 8'd0, 8'd255, 1, 255};
    tbl[5] = '{1'b1, 8'd1,   8'd1,   1'b1, 8'd2, 8'd2,   0, 1};
    tbl[6] = '{1'b1, 8'd255, 8'd0,   1'b1, 8'd9, 8'd40,  1, 41};
    tbl[7] = '{1'b1, 8'd255, 8'd255, 1'b0, 8'd0, 8'd0,   0, 255};

    // reset and reset values
    rst_n = 1'b0; ena = 1'b1; bus.rsp_ready = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_x = '0; bus.req0_y = '0;
    bus.req1_valid = 1'b0; bus.req1_x = '0; bus.req1_y = '0;
    repeat (3) step();
    settle();
    chk("rst_busy", int'(busy), 0);
    chk("rst_state", int'(dbg_state), 0);
    chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("rst_eng_start", int'(bus.eng_start), 0);
    chk("rst_eng_abort", int'(bus.eng_abort), 0);
    chk("rst_eng_xy", int'({bus.eng_x, bus.eng_y}), 0);
    chk("rst_rsp", int'({bus.rsp_id, bus.rsp_r, bus.rsp_err}), 0);
    step(); rst_n = 1'b1; settle();

    // basic job: ready same cycle, start one cycle later, result after done
    step();
    bus.rsp_ready = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_x = 8'd3; bus.req0_y = 8'd4;
    settle();
    chk("basic_ready0", int'(bus.req0_ready), 1);
    chk("basic_ready1", int'(bus.req1_ready), 0);
    step(); bus.req0_valid = 1'b0; settle();
    chk("basic_start", int'(bus.eng_start), 1);
    chk("basic_eng_x", int'(bus.eng_x), 3);
    chk("basic_eng_y", int'(bus.eng_y), 4);
    k = 0;
    while (!bus.eng_done && k < 20) begin step(); settle(); k++; end
    step(); settle();
    chk("basic_rsp_valid", int'(bus.rsp_valid), 1);
    chk("basic_rsp", int'({bus.rsp_id, bus.rsp_r, bus.rsp_err}), int'({1'b0, 8'd5, 1'b0}));
    step(); settle();
    chk("basic_rsp_drop", int'(bus.rsp_valid), 0);

    // continuous contention from reset: 0,1,0,1
    step(); rst_n = 1'b0; exp_q.delete();
    step(); step(); rst_n = 1'b1; settle();
    step();
    bus.req0_valid = 1'b1; bus.req0_x = 8'd6; bus.req0_y = 8'd8;
    bus.req1_valid = 1'b1; bus.req1_x = 8'd5; bus.req1_y = 8'd12;
    settle();
    n = 0; k = 0;
    for (int i = 0; i < 4; i++) begin ids[i] = 3; rs[i] = -1; end
    while (n < 4 && k < 300) begin
      if (bus.rsp_valid && bus.rsp_ready) begin
        ids[n] = int'(bus.rsp_id); rs[n] = int'(bus.rsp_r); n++;
      end
      if (n < 4) begin step(); settle(); end
      k++;
    end
    step(); bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; settle();
    for (int i = 0; i < 4; i++) begin
      chk("rr_id", ids[i], i % 2);
      chk("rr_r", rs[i], (i % 2) ? 13 : 10);
    end
    step(); settle();

    // table of grant / result vectors
    for (int i = 0; i < 8; i++) apply(tbl[i]);

    // watchdog expiry, then a normal job
    exp_err = 1'b1; eng_lat = 0;
    step(); bus.req0_valid = 1'b1; bus.req0_x = 8'd1; bus.req0_y = 8'd2; settle();
    chk("to_ready0", int'(bus.req0_ready), 1);
    step(); bus.req0_valid = 1'b0; settle();
    chk("to_start", int'(bus.eng_start), 1);
    t0 = cyc_n;
    wait_abort(t0, 32);
    chk("to_no_rsp_yet", int'(bus.rsp_valid), 0);
    step(); settle();
    chk("to_abort_pulse", int'(bus.eng_abort), 0);
    chk("to_rsp", int'({bus.rsp_valid, bus.rsp_r, bus.rsp_err}), int'({1'b1, 8'd0, 1'b1}));
    step(); settle();
    exp_err = 1'b0; eng_lat = 5;
    v = '{1'b0, 8'd0, 8'd0, 1'b1, 8'd8, 8'd15, 1, 17};
    apply(v);

    // back-pressure: response held, req1 blocked until the handshake
    step();
    bus.rsp_ready = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_x = 8'd0; bus.req0_y = 8'd0;
    settle();
    chk("bp_ready0", int'(bus.req0_ready), 1);
    step();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_x = 8'd5; bus.req1_y = 8'd12;
    settle();
    wait_rsp("bp_rsp_seen");
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_valid", int'(bus.rsp_valid), 1);
      chk("bp_hold_rsp", int'({bus.rsp_id, bus.rsp_r, bus.rsp_err}), 0);
      chk("bp_req1_blocked", int'(bus.req1_ready), 0);
      step(); settle();
    end
    step(); bus.rsp_ready = 1'b1; settle();
    chk("bp_hs_no_ready", int'(bus.req1_ready), 0);
    step(); settle();
    chk("bp_idle_ready1", int'(bus.req1_ready), 1);
    step(); bus.req1_valid = 1'b0; settle();
    wait_rsp("bp_rsp2_seen");
    chk("bp_rsp2", int'({bus.rsp_id, bus.rsp_r}), int'({1'b1, 8'd13}));
    step(); settle();

    // done coincident with watchdog expiry: done wins
    eng_lat = TIMEOUT;
    step(); bus.req0_valid = 1'b1; bus.req0_x = 8'd6; bus.req0_y = 8'd8; settle();
    step(); bus.req0_valid = 1'b0; settle();
    chk("co_start", int'(bus.eng_start), 1);
    k = 0;
    while (!bus.eng_done && k < 100) begin step(); settle(); k++; end
    chk("co_no_abort", int'(bus.eng_abort), 0);
    step(); settle();
    chk("co_rsp", int'({bus.rsp_valid, bus.rsp_r, bus.rsp_err}), int'({1'b1, 8'd10, 1'b0}));
    step(); settle();

    // ena low for 3 cycles in WAIT, done arrives after ena returns
    eng_lat = 8;
    step(); bus.req1_valid = 1'b1; bus.req1_x = 8'd9; bus.req1_y = 8'd12; settle();
    step(); bus.req1_valid = 1'b0; settle();
    chk("en_start", int'(bus.eng_start), 1);
    step(); settle(); step(); settle();
    for (int i = 0; i < 3; i++) begin
      step(); ena = 1'b0; settle();
      chk("en_frozen_busy", int'(busy), 1);
      chk("en_no_abort", int'(bus.eng_abort), 0);
    end
    step(); ena = 1'b1; settle();
    wait_rsp("en_rsp_seen");
    chk("en_rsp", int'({bus.rsp_id, bus.rsp_r, bus.rsp_err}), int'({1'b1, 8'd15, 1'b0}));
    step(); settle();

    // start deferred by ena, watchdog frozen 3 cycles: abort at 35
    exp_err = 1'b1; eng_lat = 0;
    step(); bus.req0_valid = 1'b1; bus.req0_x = 8'd4; bus.req0_y = 8'd4; settle();
    chk("df_ready0", int'(bus.req0_ready), 1);
    step(); bus.req0_valid = 1'b0; ena = 1'b0; settle();
    chk("df_start_masked", int'(bus.eng_start), 0);
    step(); ena = 1'b1; settle();
    chk("df_start_late", int'(bus.eng_start), 1);
    t0 = cyc_n;
    step(); settle(); step(); settle();
    for (int i = 0; i < 3; i++) begin step(); ena = 1'b0; settle(); end
    step(); ena = 1'b1; settle();
    wait_abort(t0, TIMEOUT + 3);
    step(); settle();
    chk("df_rsp_err", int'(bus.rsp_err), 1);
    step(); settle();
    exp_err = 1'b0;

    // reset during WAIT discards the job
    eng_lat = 20;
    step(); bus.req0_valid = 1'b1; bus.req0_x = 8'd3; bus.req0_y = 8'd4; settle();
    step(); bus.req0_valid = 1'b0; settle();
    step(); settle(); step(); settle();
    step(); rst_n = 1'b0; exp_q.delete(); #1;
    chk("mr_busy", int'(busy), 0);
    chk("mr_state", int'(dbg_state), 0);
    chk("mr_eng_xy", int'({bus.eng_x, bus.eng_y}), 0);
    chk("mr_rsp", int'({bus.rsp_valid, bus.rsp_id, bus.rsp_r, bus.rsp_err}), 0);
    step(); step(); rst_n = 1'b1; settle();
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      step(); settle();
      seen = seen | int'(bus.rsp_valid) | int'(busy);
    end
    chk("mr_no_rsp", seen, 0);
    eng_lat = 5;
    v = '{1'b1, 8'd255, 8'd255, 1'b0, 8'd0, 8'd0, 0, 255};
    apply(v);

    step(); settle();
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
